// File: rtl/per2axi_arb_pkg.sv
// Shared types and limits for the per2axi requester arbiter.
// Counter widths are sized for the largest supported configuration.
package per2axi_arb_pkg;

  localparam int unsigned MAX_NB_REQ    = 16;
  localparam int unsigned MAX_OUTST_LIM = 15;
  localparam int unsigned OUTST_CNT_W   = $clog2(MAX_OUTST_LIM + 1);
  localparam int unsigned STALL_CNT_W   = 16;

  typedef logic [OUTST_CNT_W-1:0] outst_cnt_t;
  typedef logic [STALL_CNT_W-1:0] stall_cnt_t;

  // Saturating increment for the stall counters.
  function automatic stall_cnt_t stall_inc(input stall_cnt_t cnt);
    return (cnt == {STALL_CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/per2axi_arb_rr.sv
// Round-robin selector: picks the first eligible requester at or after the pointer.
module per2axi_arb_rr
  import per2axi_arb_pkg::*;
#(
  parameter int unsigned NB_REQ = 4,
  parameter int unsigned IDXW   = (NB_REQ > 1) ? $clog2(NB_REQ) : 1
) (
  input  logic [NB_REQ-1:0] i_elig,
  input  logic [IDXW-1:0]   i_ptr,
  output logic [IDXW-1:0]   o_sel,
  output logic              o_valid
);

  // Walk offsets from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    o_valid = 1'b0;
    o_sel   = '0;
    for (int off = NB_REQ - 1; off >= 0; off--) begin
      if (i_elig[(int'(i_ptr) + off) % NB_REQ]) begin
        o_valid = 1'b1;
        o_sel   = IDXW'((int'(i_ptr) + off) % NB_REQ);
      end
    end
  end

endmodule

// File: rtl/per2axi_arb.sv
// Arbitrates NB_REQ peripheral requesters onto one per2axi bridge and routes responses by ID.
// Optional per-requester stall counters are enabled with PER2AXI_ARB_PERF_EN.
module per2axi_arb
  import per2axi_arb_pkg::*;
#(
  parameter int unsigned NB_REQ    = 4,
  parameter int unsigned ID_WIDTH  = 5,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NB_REQ-1:0]        req_i,
  input  logic [NB_REQ-1:0][31:0]  add_i,
  input  logic [NB_REQ-1:0]        wen_i,
  input  logic [NB_REQ-1:0][31:0]  wdata_i,
  input  logic [NB_REQ-1:0][3:0]   be_i,
  output logic [NB_REQ-1:0]        gnt_o,
  output logic [NB_REQ-1:0]        r_valid_o,
  output logic [31:0]              r_rdata_o,
  output logic                     r_opc_o,
  output logic                     per_req_o,
  output logic [31:0]              per_add_o,
  output logic                     per_wen_o,
  output logic [31:0]              per_wdata_o,
  output logic [3:0]               per_be_o,
  output logic [ID_WIDTH-1:0]      per_id_o,
  input  logic                     per_gnt_i,
  input  logic                     per_r_valid_i,
  input  logic [ID_WIDTH-1:0]      per_r_id_i,
  input  logic [31:0]              per_r_rdata_i,
  input  logic                     per_r_opc_i,
  output logic                     busy_o
`ifdef PER2AXI_ARB_PERF_EN
  ,
  output logic [NB_REQ-1:0][STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int unsigned IDXW = $clog2(NB_REQ);
  localparam outst_cnt_t  OUTST_MAX = outst_cnt_t'(MAX_OUTST);

  if (NB_REQ < 2 || NB_REQ > MAX_NB_REQ) begin : g_bad_nb_req
    $error("per2axi_arb: NB_REQ out of range");
  end
  if (ID_WIDTH < IDXW) begin : g_bad_id_width
    $error("per2axi_arb: ID_WIDTH too small for NB_REQ");
  end
  if (MAX_OUTST < 1 || MAX_OUTST > MAX_OUTST_LIM) begin : g_bad_max_outst
    $error("per2axi_arb: MAX_OUTST out of range");
  end

  logic [IDXW-1:0]   r_ptr;
  outst_cnt_t        r_outst [NB_REQ];
  logic              r_err;

  logic [NB_REQ-1:0] w_elig;
  logic [IDXW-1:0]   w_sel;
  logic              w_sel_valid;
  logic              w_hs;
  logic [IDXW-1:0]   w_ptr_nxt;
  logic              w_id_in_range;
  logic [IDXW-1:0]   w_rsp_idx;
  logic              w_rsp_ok;
  logic              w_any_outst;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NB_REQ; i++) begin
      w_elig[i] = req_i[i] & (r_outst[i] < OUTST_MAX);
    end
  end

  per2axi_arb_rr #(
    .NB_REQ (NB_REQ),
    .IDXW   (IDXW)
  ) u_rr (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_sel   (w_sel),
    .o_valid (w_sel_valid)
  );

  assign per_req_o   = w_sel_valid & ~rst_i;
  assign per_add_o   = add_i[w_sel];
  assign per_wen_o   = wen_i[w_sel];
  assign per_wdata_o = wdata_i[w_sel];
  assign per_be_o    = be_i[w_sel];
  assign per_id_o    = ID_WIDTH'(w_sel);

  assign w_hs      = per_req_o & per_gnt_i;
  assign w_ptr_nxt = (w_sel == IDXW'(NB_REQ - 1)) ? '0 : w_sel + 1'b1;

  // Responses for unknown IDs or idle requesters are swallowed and flagged.
  assign w_id_in_range = (32'(per_r_id_i) < NB_REQ);
  assign w_rsp_idx     = per_r_id_i[IDXW-1:0];
  assign w_rsp_ok      = per_r_valid_i & ~rst_i & w_id_in_range &
                         (r_outst[w_rsp_idx] != '0);

  always_comb begin
    gnt_o       = '0;
    r_valid_o   = '0;
    w_any_outst = 1'b0;
    for (int k = 0; k < NB_REQ; k++) begin
      gnt_o[k]     = w_hs & (w_sel == IDXW'(k));
      r_valid_o[k] = w_rsp_ok & (w_rsp_idx == IDXW'(k));
      w_any_outst  = w_any_outst | (r_outst[k] != '0);
    end
  end

  assign r_rdata_o = per_r_rdata_i;
  assign r_opc_o   = per_r_opc_i;
  assign busy_o    = (|req_i) | w_any_outst;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < NB_REQ; k++) begin
        r_outst[k] <= '0;
      end
    end else begin
      if (w_hs) begin
        r_ptr <= w_ptr_nxt;
      end
      if (per_r_valid_i & ~w_rsp_ok) begin
        r_err <= 1'b1;
      end
      for (int k = 0; k < NB_REQ; k++) begin
        if (gnt_o[k] & ~r_valid_o[k]) begin
          r_outst[k] <= r_outst[k] + 1'b1;
        end else if (r_valid_o[k] & ~gnt_o[k]) begin
          r_outst[k] <= r_outst[k] - 1'b1;
        end
      end
    end
  end

`ifdef PER2AXI_ARB_PERF_EN
  stall_cnt_t r_stall [NB_REQ];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NB_REQ; k++) begin
        r_stall[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NB_REQ; k++) begin
        if (req_i[k] & ~gnt_o[k]) begin
          r_stall[k] <= stall_inc(r_stall[k]);
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      stall_cnt_o[k] = r_stall[k];
    end
  end
`endif

endmodule

// File: tb/tb_per2axi_arb.sv
// Self-checking bench for per2axi_arb: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_per2axi_arb;

  localparam int N     = 4;
  localparam int IDW   = 5;
  localparam int MAXO  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0][31:0] add;
  logic [N-1:0]      wen;
  logic [N-1:0][31:0] wdata;
  logic [N-1:0][3:0] be;
  logic [N-1:0]      gnt_o;
  logic [N-1:0]      r_valid_o;
  logic [31:0]       r_rdata_o;
  logic              r_opc_o;
  logic              per_req_o;
  logic [31:0]       per_add_o;
  logic              per_wen_o;
  logic [31:0]       per_wdata_o;
  logic [3:0]        per_be_o;
  logic [IDW-1:0]    per_id_o;
  logic              per_gnt;
  logic              per_r_valid;
  logic [IDW-1:0]    per_r_id;
  logic [31:0]       per_r_rdata;
  logic              per_r_opc;
  logic              busy_o;
`ifdef PER2AXI_ARB_PERF_EN
  logic [N-1:0][15:0] stall_cnt_o;
`endif

  per2axi_arb #(
    .NB_REQ    (N),
    .ID_WIDTH  (IDW),
    .MAX_OUTST (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .add_i         (add),
    .wen_i         (wen),
    .wdata_i       (wdata),
    .be_i          (be),
    .gnt_o         (gnt_o),
    .r_valid_o     (r_valid_o),
    .r_rdata_o     (r_rdata_o),
    .r_opc_o       (r_opc_o),
    .per_req_o     (per_req_o),
    .per_add_o     (per_add_o),
    .per_wen_o     (per_wen_o),
    .per_wdata_o   (per_wdata_o),
    .per_be_o      (per_be_o),
    .per_id_o      (per_id_o),
    .per_gnt_i     (per_gnt),
    .per_r_valid_i (per_r_valid),
    .per_r_id_i    (per_r_id),
    .per_r_rdata_i (per_r_rdata),
    .per_r_opc_i   (per_r_opc),
    .busy_o        (busy_o)
`ifdef PER2AXI_ARB_PERF_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  int m_cnt   [N];
  int m_stall [N];
  int m_ptr = 0;
  bit m_err = 1'b0;

  int           e_sel;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_rv;
  bit           e_rok;
  bit           e_busy;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_cnt[i]   = 0;
      m_stall[i] = 0;
    end
  end

  always @(negedge clk) begin
    e_busy = (req != 0);
    for (int i = 0; i < N; i++) if (m_cnt[i] != 0) e_busy = 1'b1;
    chk("busy", busy_o, e_busy);
    chk("rdata", r_rdata_o, per_r_rdata);
    chk("opc", r_opc_o, per_r_opc);
    chk("err_state", dut.r_err, m_err);
    chk("ptr_state", dut.r_ptr, m_ptr);
    for (int i = 0; i < N; i++) chk("cnt_state", dut.r_outst[i], m_cnt[i]);
`ifdef PER2AXI_ARB_PERF_EN
    for (int i = 0; i < N; i++) chk("stall_cnt", stall_cnt_o[i], m_stall[i]);
`endif
    if (rst) begin
      chk("rst_gnt", gnt_o, 0);
      chk("rst_rvalid", r_valid_o, 0);
      chk("rst_per_req", per_req_o, 0);
      m_ptr = 0;
      m_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_cnt[i]   = 0;
        m_stall[i] = 0;
      end
    end else begin
      e_sel = -1;
      for (int off = 0; off < N; off++) begin
        int j;
        j = (m_ptr + off) % N;
        if (e_sel < 0 && req[j] && m_cnt[j] < MAXO) e_sel = j;
      end
      chk("per_req", per_req_o, e_sel >= 0);
      e_gnt = '0;
      if (e_sel >= 0) begin
        chk("per_id", per_id_o, e_sel);
        chk("per_add", per_add_o, add[e_sel]);
        chk("per_wen", per_wen_o, wen[e_sel]);
        chk("per_wdata", per_wdata_o, wdata[e_sel]);
        chk("per_be", per_be_o, be[e_sel]);
        if (per_gnt) e_gnt[e_sel] = 1'b1;
      end
      chk("gnt", gnt_o, e_gnt);
      e_rok = per_r_valid && (int'(per_r_id) < N) && (m_cnt[per_r_id % N] > 0);
      e_rv  = '0;
      if (e_rok) e_rv[per_r_id % N] = 1'b1;
      chk("r_valid", r_valid_o, e_rv);
      for (int i = 0; i < N; i++)
        if (req[i] && !e_gnt[i] && m_stall[i] < 65535) m_stall[i]++;
      if (e_rok) m_cnt[per_r_id % N]--;
      else if (per_r_valid) m_err = 1'b1;
      if (e_gnt != 0) begin
        m_cnt[e_sel]++;
        m_ptr = (e_sel + 1) % N;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req         = '0;
    per_gnt     = 1'b0;
    per_r_valid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int k = 0; k < N; k++) begin
      for (int t = 0; t < 2 * MAXO && m_cnt[k] > 0; t++) begin
        per_r_valid = 1'b1;
        per_r_id    = IDW'(k);
        cyc();
      end
    end
    per_r_valid = 1'b0;
    for (int k = 0; k < N; k++) chk("drain_done", m_cnt[k], 0);
  endtask

  int exp_ids [3] = '{3, 0, 1};

  initial begin
    rst         = 1'b1;
    req         = 4'b1111;
    per_gnt     = 1'b1;
    per_r_valid = 1'b1;
    per_r_id    = '0;
    per_r_rdata = 32'h1234_5678;
    per_r_opc   = 1'b0;
    for (int i = 0; i < N; i++) begin
      add[i]   = 32'h1000_0000 + i * 32'h100;
      wdata[i] = 32'hA5A5_0000 + i;
      wen[i]   = i[0];
      be[i]    = 4'hF >> i;
    end
    #2;
    chk("lit_rst_gnt", gnt_o, 0);
    chk("lit_rst_per_req", per_req_o, 0);
    chk("lit_rst_rvalid", r_valid_o, 0);
    cyc();
    cyc();

    // Full contention: strict rotation 0..3 from reset
    rst = 1'b0;
    per_r_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      #2;
      chk("lit_rr_id", per_id_o, i);
      chk("lit_rr_gnt", gnt_o, 4'b0001 << i);
      cyc();
    end
    drain();

    // Requester 2 saturates at MAX_OUTST and is skipped
    req = 4'b0100;
    per_gnt = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("lit_r2_id", per_id_o, 2);
      cyc();
    end
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lit_masked_id", per_id_o, exp_ids[i]);
      cyc();
    end
    per_gnt     = 1'b0;
    per_r_valid = 1'b1;
    per_r_id    = 5'd2;
    #2;
    chk("lit_masked_stall_id", per_id_o, 3);
    chk("lit_r2_rvalid", r_valid_o, 4'b0100);
    chk("lit_stall_gnt", gnt_o, 0);
    cyc();
    per_r_valid = 1'b0;
    #2;
    chk("lit_r2_back", per_id_o, 2);
    drain();

    // Same-cycle grant and response on requester 1
    req = 4'b0010;
    per_gnt = 1'b1;
    cyc();
    per_r_valid = 1'b1;
    per_r_id    = 5'd1;
    #2;
    chk("lit_same_gnt", gnt_o, 4'b0010);
    chk("lit_same_rvalid", r_valid_o, 4'b0010);
    cyc();
    idle();
    chk("lit_same_cnt", dut.r_outst[1], 1);
    drain();

    // Out-of-range response ID
    per_r_valid = 1'b1;
    per_r_id    = 5'd7;
    #2;
    chk("lit_bad_id_rvalid", r_valid_o, 0);
    cyc();
    per_r_valid = 1'b0;
    chk("lit_bad_id_err", dut.r_err, 1);
    #2;
    chk("lit_bad_id_busy", busy_o, 0);
    cyc();

    // Reset with work in flight and the bridge stalled
    req = 4'b0001;
    per_gnt = 1'b1;
    cyc();
    cyc();
    chk("lit_r0_cnt2", dut.r_outst[0], 2);
    per_gnt = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    per_gnt = 1'b1;
    #2;
    chk("lit_midrst_gnt", gnt_o, 0);
    chk("lit_midrst_per_req", per_req_o, 0);
    cyc();
    rst = 1'b0;
    idle();
    chk("lit_post_rst_cnt", dut.r_outst[0], 0);
    chk("lit_post_rst_ptr", dut.r_ptr, 0);
    #2;
    chk("lit_post_rst_busy", busy_o, 0);
    cyc();
    per_r_valid = 1'b1;
    per_r_id    = 5'd0;
    #2;
    chk("lit_stale_rvalid", r_valid_o, 0);
    cyc();
    per_r_valid = 1'b0;
    chk("lit_stale_err", dut.r_err, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 4'b0001;
    per_gnt = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
`ifdef PER2AXI_ARB_PERF_EN
    chk("lit_stall5", stall_cnt_o[0], 5);
`endif
    chk("lit_stall_err_clr", dut.r_err, 0);
    idle();
    cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      req     = N'($urandom);
      per_gnt = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        add[i]   = $urandom;
        wdata[i] = $urandom;
        wen[i]   = $urandom_range(0, 1);
        be[i]    = 4'($urandom);
      end
      per_r_rdata = $urandom;
      per_r_opc   = $urandom_range(0, 1);
      per_r_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, N - 1);
        if ($urandom_range(0, 15) == 0) begin
          per_r_valid = 1'b1;
          per_r_id    = IDW'($urandom);
        end else if (m_cnt[k] > 0) begin
          per_r_valid = 1'b1;
          per_r_id    = IDW'(k);
        end
      end
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
